fifo_channel_module: RTL and testbench

KPN channel FIFO that buffers the 16-bit token stream produced by an arithmetic process stage, such as the subtractor, and hands it to the next process under blocking read/write semantics. It sits directly downstream of an arithmetic stage. Its write side samples the stage's registered result, and its read side feeds the consuming process. Full/empty flags implement Kahn blocking, and overflow/underflow attempts are rejected and flagged, never silently corrupting data.

---
 rtl/fifo_channel_module.sv | 104 ++++++++++
 tb/tb_fifo_channel_module.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_channel_module.sv
// KPN channel FIFO: 16-bit tokens with Kahn blocking on full/empty.
// Rejected reads and writes are flagged for one cycle and never alter the stored data.
module fifo_channel_module #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           entry_1,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [15:0]           output_1,
  output logic                  output_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  write_error,
  output logic                  read_error
);

  localparam logic [ADDR_WIDTH:0] CountMax = (ADDR_WIDTH + 1)'(DEPTH);

  logic [15:0]           mem_q [DEPTH];
  logic [15:0]           mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [15:0]           out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  werr_q, werr_d;
  logic                  rerr_q, rerr_d;
  logic                  full_w, empty_w;
  logic                  rd_acc, wr_acc;

  always_comb begin
    full_w  = (count_q == CountMax);
    empty_w = (count_q == '0);
    rd_acc  = read_enable & ~empty_w;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    wr_acc  = write_enable & (~full_w | rd_acc);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    werr_d   = write_enable & ~wr_acc;
    rerr_d   = read_enable & empty_w;

    if (wr_acc) begin
      mem_d[wr_ptr_q] = entry_1;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end

    if (rd_acc) begin
      out_d    = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= 16'h0000;
      valid_q  <= 1'b0;
      werr_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      werr_q   <= werr_d;
      rerr_q   <= rerr_d;
    end
  end

  // Storage is not cleared by reset; it only has to ignore writes during reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

  assign output_1     = out_q;
  assign output_valid = valid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_q;
  assign write_error  = werr_q;
  assign read_error   = rerr_q;

endmodule

// File: tb/tb_fifo_channel_module.sv
// Directed vector bench for fifo_channel_module: a table of per-cycle
// inputs/expected outputs plus hand-written wrap-around and mid-stream reset sequences.
module tb_fifo_channel_module;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic        re;
    logic [15:0] din;
    logic [15:0] out;
    logic        vld;
    logic        full;
    logic        empty;
    logic [3:0]  cnt;
    logic        werr;
    logic        rerr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] entry_1;
  logic        write_enable;
  logic        read_enable;
  logic [15:0] output_1;
  logic        output_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        write_error;
  logic        read_error;

  int n_cmp;
  int n_fail;

  fifo_channel_module #(
    .DEPTH      (8),
    .ADDR_WIDTH (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entry_1      (entry_1),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .output_1     (output_1),
    .output_valid (output_valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .write_error  (write_error),
    .read_error   (read_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic w, logic rd, logic [15:0] d, logic [15:0] o,
                              logic v, logic f, logic e, logic [3:0] c, logic we_err,
                              logic re_err);
    vec_t t;
    t.rst_n = r;  t.we = w;    t.re = rd;    t.din = d;
    t.out = o;    t.vld = v;   t.full = f;   t.empty = e;
    t.cnt = c;    t.werr = we_err; t.rerr = re_err;
    return t;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", tag, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare all outputs.
  task automatic apply(input string tag, input int idx, input vec_t v);
    rst_n        = v.rst_n;
    write_enable = v.we;
    read_enable  = v.re;
    entry_1      = v.din;
    @(posedge clk);
    #1;
    chk({tag, ".output_1"},     idx, output_1,              v.out);
    chk({tag, ".output_valid"}, idx, {15'd0, output_valid}, {15'd0, v.vld});
    chk({tag, ".full"},         idx, {15'd0, full},         {15'd0, v.full});
    chk({tag, ".empty"},        idx, {15'd0, empty},        {15'd0, v.empty});
    chk({tag, ".count"},        idx, {12'd0, count},        {12'd0, v.cnt});
    chk({tag, ".write_error"},  idx, {15'd0, write_error},  {15'd0, v.werr});
    chk({tag, ".read_error"},   idx, {15'd0, read_error},   {15'd0, v.rerr});
  endtask

  vec_t tbl[$];

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    entry_1      = 16'h0000;

    // Reset held two cycles with a write pending: nothing may be stored.
    tbl.push_back(mk(0, 1, 0, 16'h1234, 16'h0000, 0, 0, 1, 4'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h1234, 16'h0000, 0, 0, 1, 4'd0, 0, 0));
    // Ordered fill 1..8.
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, 1, 0, 16'(i), 16'h0000, 0, (i == 8), 0, 4'(i), 0, 0));
    // Overflow: dropped and flagged for one cycle only.
    tbl.push_back(mk(1, 1, 0, 16'hBEEF, 16'h0000, 0, 1, 0, 4'd8, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 4'd8, 0, 0));
    // Drain: 1..8 in order, never BEEF.
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, 0, 1, 16'h0000, 16'(i), 1, 0, (i == 8), 4'(8 - i), 0, 0));
    // Underflow: output holds.
    tbl.push_back(mk(1, 0, 1, 16'h0000, 16'h0008, 0, 0, 1, 4'd0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0008, 0, 0, 1, 4'd0, 0, 0));
    // Read+write on empty: no fall-through.
    tbl.push_back(mk(1, 1, 1, 16'h00AA, 16'h0008, 0, 0, 0, 4'd1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0000, 16'h00AA, 1, 0, 1, 4'd0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply("tbl", i, tbl[i]);

    // Full read+write with pointer wrap (pointers start at 1 here).
    for (int i = 1; i <= 8; i++)
      apply("wrap_fill", i, mk(1, 1, 0, 16'(i), 16'h00AA, 0, (i == 8), 0, 4'(i), 0, 0));
    for (int i = 0; i < 10; i++) begin
      logic [15:0] exp_out;
      exp_out = (i < 8) ? 16'(i + 1) : 16'(16'h0100 + i - 8);
      apply("wrap_rw", i, mk(1, 1, 1, 16'(16'h0100 + i), exp_out, 1, 1, 0, 4'd8, 0, 0));
    end

    // Drain to 5 tokens, then reset mid-stream with a write pending.
    for (int i = 0; i < 3; i++)
      apply("pre_rst", i, mk(1, 0, 1, 16'h0000, 16'(16'h0102 + i), 1, 0, 0, 4'(7 - i), 0, 0));
    apply("mid_rst", 0, mk(0, 1, 1, 16'h7777, 16'h0000, 0, 0, 1, 4'd0, 0, 0));
    apply("post_rst", 0, mk(1, 1, 0, 16'h5555, 16'h0000, 0, 0, 0, 4'd1, 0, 0));
    apply("post_rst", 1, mk(1, 0, 1, 16'h0000, 16'h5555, 1, 0, 1, 4'd0, 0, 0));
    apply("post_rst", 2, mk(1, 0, 0, 16'h0000, 16'h5555, 0, 0, 1, 4'd0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
